m68k_bus_ctrl: RTL and testbench

M68K_BUS_CTRL -- requirements
Module: m68k_bus_ctrl

---
 rtl/m68k_bus_pkg.sv | 35 +++
 rtl/m68k_ipl_enc.sv | 29 ++
 rtl/m68k_bus_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_m68k_bus_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus controller.
//   bus_state_t : bus cycle state encoding
//   FC_IACK     : function code of an interrupt-acknowledge cycle
//   DEF_BASE    : default region bases (region i at word address i<<15)
//   region_hit  : address-region match test
package m68k_bus_pkg;

   localparam int unsigned ADDR_W  = 23;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned WAIT_W  = 4;
   localparam int unsigned MAX_REG = 8;

   localparam logic [2:0] FC_IACK = 3'b111;

   localparam logic [MAX_REG*ADDR_W-1:0] DEF_BASE = {
      23'h038000, 23'h030000, 23'h028000, 23'h020000,
      23'h018000, 23'h010000, 23'h008000, 23'h000000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WAIT,
      ST_ACK,
      ST_BERR
   } bus_state_t;

   // Region match: masked address equals the region base.
   function automatic logic region_hit(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/m68k_ipl_enc.sv
// Interrupt priority encoder for the 68000 IPL inputs.
//   clk, reset_n : clock, synchronous active-low reset
//   irq[6:0]     : level requests, bit k is level k+1
//   phi2         : update enable, ipl_n changes only when phi2 is high
//   ipl_n[2:0]   : active-low encoded highest pending level
module m68k_ipl_enc (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] irq,
   input  logic       phi2,
   output logic [2:0] ipl_n
);

   logic [2:0] level_c;

   // Highest asserted level wins.
   always_comb begin
      level_c = 3'd0;
      for (int k = 0; k < 7; k++) begin
         if (irq[k]) level_c = 3'(k + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)  ipl_n <= 3'b111;
      else if (phi2) ipl_n <= ~level_c;
   end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: CPU phase enables, region decode, wait states,
// DTACK/VPA/BERR generation, read-data mux and interrupt level encoding.
//   clk, reset_n              : clock, synchronous active-low reset
//   phi1, phi2                : CPU phase enables
//   as_n, rw, uds_n, lds_n    : CPU bus strobes
//   fc, cpu_a                 : function code, word address A23:A1
//   dtack_n, berr_n, vpa_n    : CPU acknowledges
//   cpu_din                   : read data to CPU
//   reg_din, rdy              : per-region read data and ready
//   sel, we, re               : one-hot region select, qualified strobes
//   irq, ipl_n                : interrupt requests, encoded level
module m68k_bus_ctrl
   import m68k_bus_pkg::*;
#(
   parameter int unsigned                N_REG    = 4,
   parameter int unsigned                CLK_DIV  = 1,
   parameter logic [N_REG*ADDR_W-1:0]    REG_BASE = DEF_BASE[N_REG*ADDR_W-1:0],
   parameter logic [N_REG*ADDR_W-1:0]    REG_MASK = {N_REG{23'h7FC000}},
   parameter logic [N_REG*WAIT_W-1:0]    REG_WAIT = '0,
   parameter logic [N_REG-1:0]           REG_RDY  = '0,
   parameter int unsigned                BERR_TO  = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   output logic                    phi1,
   output logic                    phi2,
   input  logic                    as_n,
   input  logic                    rw,
   input  logic                    uds_n,
   input  logic                    lds_n,
   input  logic [2:0]              fc,
   input  logic [23:1]             cpu_a,
   output logic                    dtack_n,
   output logic                    berr_n,
   output logic                    vpa_n,
   output logic [DATA_W-1:0]       cpu_din,
   input  logic [N_REG*DATA_W-1:0] reg_din,
   input  logic [N_REG-1:0]        rdy,
   output logic [N_REG-1:0]        sel,
   output logic                    we,
   output logic                    re,
   input  logic [6:0]              irq,
   output logic [2:0]              ipl_n
);

   localparam int unsigned PHI_W = $clog2(2 * CLK_DIV);
   localparam int unsigned TO_W  = $clog2(BERR_TO + 1);

   bus_state_t         state, state_nxt;
   logic [PHI_W-1:0]   phi_cnt;
   logic [TO_W-1:0]    to_cnt, to_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt, wait_c;
   logic [N_REG-1:0]   hit_c, sel_nxt;
   logic               iack_q, iack_nxt, iack_c;
   logic               armed, armed_nxt;
   logic               timeout_c, rdy_ok_c;
   logic               dtack_nxt, berr_nxt, vpa_nxt, we_nxt, re_nxt;
   logic [DATA_W-1:0]  din_nxt;

   // Lowest-index hitting region and its wait-state count.
   always_comb begin
      hit_c  = '0;
      wait_c = '0;
      for (int i = int'(N_REG) - 1; i >= 0; i--) begin
         if (region_hit(cpu_a, REG_BASE[i*ADDR_W +: ADDR_W], REG_MASK[i*ADDR_W +: ADDR_W])) begin
            hit_c    = '0;
            hit_c[i] = 1'b1;
            wait_c   = REG_WAIT[i*WAIT_W +: WAIT_W];
         end
      end
   end

   assign iack_c    = (fc == FC_IACK) && (&cpu_a[23:4]);
   assign timeout_c = (to_cnt == TO_W'(BERR_TO - 1));
   assign rdy_ok_c  = ((sel & REG_RDY & ~rdy) == '0);

   // Next state and next register values; outputs follow the next state.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      iack_nxt  = iack_q;
      wait_nxt  = wait_cnt;
      to_nxt    = to_cnt;
      armed_nxt = armed;
      din_nxt   = '0;

      // A new cycle needs as_n seen high first, so a strobe held across reset is ignored.
      if (as_n) armed_nxt = 1'b1;

      case (state)
         ST_IDLE: begin
            to_nxt = '0;
            if (armed && !as_n && (!uds_n || !lds_n)) begin
               state_nxt = ST_DECODE;
               armed_nxt = 1'b0;
            end
         end
         ST_DECODE: begin
            to_nxt   = to_cnt + 1'b1;
            sel_nxt  = iack_c ? '0 : hit_c;
            iack_nxt = iack_c;
            wait_nxt = wait_c;
            if (as_n)           state_nxt = ST_IDLE;
            else if (timeout_c) state_nxt = ST_BERR;
            else if (iack_c)    state_nxt = ST_ACK;
            else                state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            to_nxt = to_cnt + 1'b1;
            if (wait_cnt != '0) wait_nxt = wait_cnt - 1'b1;
            // Unmapped cycles (sel=0) can only leave via timeout or abort.
            if (as_n)           state_nxt = ST_IDLE;
            else if (timeout_c) state_nxt = ST_BERR;
            else if ((sel != '0) && (wait_cnt == '0) && rdy_ok_c) state_nxt = ST_ACK;
         end
         ST_ACK, ST_BERR: begin
            if (as_n) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (state_nxt == ST_IDLE) begin
         sel_nxt  = '0;
         iack_nxt = 1'b0;
      end

      dtack_nxt = !((state_nxt == ST_ACK) && !iack_nxt);
      vpa_nxt   = !((state_nxt == ST_ACK) && iack_nxt);
      berr_nxt  = (state_nxt != ST_BERR);
      we_nxt    = ((state_nxt == ST_WAIT) || (state_nxt == ST_ACK)) && (sel_nxt != '0) && !rw;
      re_nxt    = ((state_nxt == ST_WAIT) || (state_nxt == ST_ACK)) && (sel_nxt != '0) && rw;

      for (int i = 0; i < int'(N_REG); i++) begin
         if (sel[i]) din_nxt = reg_din[i*DATA_W +: DATA_W];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Datapath, phase counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phi_cnt  <= '0;
         phi1     <= 1'b0;
         phi2     <= 1'b0;
         to_cnt   <= '0;
         wait_cnt <= '0;
         sel      <= '0;
         iack_q   <= 1'b0;
         armed    <= 1'b0;
         dtack_n  <= 1'b1;
         berr_n   <= 1'b1;
         vpa_n    <= 1'b1;
         we       <= 1'b0;
         re       <= 1'b0;
         cpu_din  <= '0;
      end else begin
         phi_cnt  <= (phi_cnt == PHI_W'(2 * CLK_DIV - 1)) ? '0 : phi_cnt + 1'b1;
         phi1     <= (phi_cnt == PHI_W'(CLK_DIV - 1));
         phi2     <= (phi_cnt == PHI_W'(2 * CLK_DIV - 1));
         to_cnt   <= to_nxt;
         wait_cnt <= wait_nxt;
         sel      <= sel_nxt;
         iack_q   <= iack_nxt;
         armed    <= armed_nxt;
         dtack_n  <= dtack_nxt;
         berr_n   <= berr_nxt;
         vpa_n    <= vpa_nxt;
         we       <= we_nxt;
         re       <= re_nxt;
         cpu_din  <= din_nxt;
      end
   end

   m68k_ipl_enc u_ipl_enc (
      .clk     (clk),
      .reset_n (reset_n),
      .irq     (irq),
      .phi2    (phi2),
      .ipl_n   (ipl_n)
   );

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Randomized self-checking bench for m68k_bus_ctrl. Expected ack timing is
// derived from the region rules: ack on sample 3+wait (or one after rdy),
// berr on sample BERR_TO+1, autovector on sample 2.
module tb_m68k_bus_ctrl;

   localparam int unsigned N_REG   = 4;
   localparam int unsigned BERR_TO = 255;
   localparam logic [15:0] P_WAIT  = {4'd5, 4'd2, 4'd0, 4'd0};
   localparam logic [3:0]  P_RDY   = 4'b1000;
   localparam int          WAITS [4] = '{0, 0, 2, 5};
   localparam logic [2:0]  K_DTACK = 3'b100;
   localparam logic [2:0]  K_BERR  = 3'b010;
   localparam logic [2:0]  K_VPA   = 3'b001;

   logic        clk = 1'b0;
   logic        reset_n, phi1, phi2, as_n, rw, uds_n, lds_n;
   logic [2:0]  fc, ipl_n;
   logic [23:1] cpu_a;
   logic        dtack_n, berr_n, vpa_n, we, re;
   logic [15:0] cpu_din;
   logic [63:0] reg_din;
   logic [3:0]  rdy, sel;
   logic [6:0]  irq;
   logic [2:0]  exp_ipl;
   int          n_chk, n_bad;

   always #5 clk = ~clk;

   m68k_bus_ctrl #(
      .N_REG(N_REG), .CLK_DIV(1), .REG_WAIT(P_WAIT), .REG_RDY(P_RDY), .BERR_TO(BERR_TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .phi1(phi1), .phi2(phi2),
      .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n), .fc(fc), .cpu_a(cpu_a),
      .dtack_n(dtack_n), .berr_n(berr_n), .vpa_n(vpa_n), .cpu_din(cpu_din),
      .reg_din(reg_din), .rdy(rdy), .sel(sel), .we(we), .re(re),
      .irq(irq), .ipl_n(ipl_n)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int region_of(input logic [23:1] a);
      int r;
      r = -1;
      for (int i = N_REG - 1; i >= 0; i--)
         if ((a & 23'h7FC000) == 23'(i << 15)) r = i;
      return r;
   endfunction

   function automatic logic [2:0] ipl_model(input logic [6:0] v);
      for (int k = 6; k >= 0; k--)
         if (v[k]) return ~3'(k + 1);
      return 3'b111;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Change irq right after phi1 so the next edge must hold and the one after must update.
   task automatic ipl_step(input logic [6:0] v);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         tick();
         if (phi1) found = 1'b1;
      end
      check_eq("phi1_found", 64'(found), 64'(1));
      irq = v;
      tick();
      check_eq("ipl_hold", 64'(ipl_n), 64'(exp_ipl));
      tick();
      exp_ipl = ipl_model(v);
      check_eq("ipl_upd", 64'(ipl_n), 64'(exp_ipl));
   endtask

   task automatic run_txn(input logic [23:1] a, input logic [2:0] f, input logic r, input int rdy_dly);
      int ri, exp_n, got_n, bs;
      logic iack;
      logic [2:0] exp_k, got_k;
      logic [3:0] exp_sel;
      logic [15:0] exp_din;
      logic [1:0] exp_wr;
      iack    = (f == 3'b111) && (&a[23:4]);
      ri      = iack ? -1 : region_of(a);
      exp_sel = (ri >= 0) ? 4'(1 << ri) : 4'b0000;
      exp_din = (ri >= 0) ? reg_din[ri*16 +: 16] : 16'h0000;
      if (iack) begin
         exp_n = 2; exp_k = K_VPA;
      end else if (ri < 0) begin
         exp_n = BERR_TO + 1; exp_k = K_BERR;
      end else begin
         exp_n = 3 + WAITS[ri];
         if (P_RDY[ri] && (rdy_dly + 1 > exp_n)) exp_n = rdy_dly + 1;
         exp_k = K_DTACK;
         if (exp_n > BERR_TO) begin
            exp_n = BERR_TO + 1; exp_k = K_BERR;
         end
      end
      exp_wr = (exp_k == K_DTACK) ? {!r, r} : 2'b00;

      cpu_a = a; fc = f; rw = r; rdy = '0;
      bs = $urandom_range(0, 2);
      uds_n = (bs == 1); lds_n = (bs == 0); as_n = 1'b0;
      got_n = 0; got_k = '0;
      for (int n = 1; n <= BERR_TO + 40 && got_n == 0; n++) begin
         tick();
         if (n == 2) begin
            check_eq("sel", 64'(sel), 64'(exp_sel));
            check_eq("we_re_wait", 64'({we, re}), 64'((exp_sel != 0) ? {!r, r} : 2'b00));
         end
         if ({dtack_n, berr_n, vpa_n} != 3'b111) begin
            got_n = n;
            got_k = ~{dtack_n, berr_n, vpa_n};
            check_eq("cpu_din", 64'(cpu_din), 64'(exp_din));
            check_eq("we_re_ack", 64'({we, re}), 64'(exp_wr));
         end
         if (n == rdy_dly && ri >= 0) rdy[ri] = 1'b1;
      end
      check_eq("ack_sample", 64'(got_n), 64'(exp_n));
      check_eq("ack_kind", 64'(got_k), 64'(exp_k));

      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      tick();
      check_eq("release_acks", 64'({dtack_n, berr_n, vpa_n}), 64'(3'b111));
      check_eq("release_sel", 64'({sel, we, re}), 64'(0));
      rdy = '0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic run_abort(input int n_ab);
      cpu_a = 23'(3 << 15); fc = 3'b101; rw = 1'b0; rdy = '0;
      uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
      for (int n = 1; n <= n_ab; n++) begin
         tick();
         check_eq("abort_noack", 64'({dtack_n, berr_n, vpa_n}), 64'(3'b111));
      end
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (3) begin
         tick();
         check_eq("abort_idle", 64'({dtack_n, berr_n, vpa_n, sel, we}), 64'(8'b111_0000_0));
      end
   endtask

   initial begin
      n_chk = 0; n_bad = 0; exp_ipl = 3'b111;
      reset_n = 1'b0; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      fc = 3'b000; cpu_a = '0; reg_din = '0; rdy = '0; irq = '0;

      repeat (3) tick();
      check_eq("rst_acks", 64'({dtack_n, berr_n, vpa_n}), 64'(3'b111));
      check_eq("rst_phi", 64'({phi1, phi2}), 64'(2'b00));
      check_eq("rst_sel_we_re", 64'({sel, we, re}), 64'(0));
      check_eq("rst_din", 64'(cpu_din), 64'(0));
      check_eq("rst_ipl", 64'(ipl_n), 64'(3'b111));

      reset_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         check_eq("phi1", 64'(phi1), 64'(j % 2 == 0));
         check_eq("phi2", 64'(phi2), 64'(j % 2 == 1));
      end
      check_eq("idle_acks", 64'({dtack_n, berr_n, vpa_n}), 64'(3'b111));

      ipl_step(7'b0010010);
      for (int t = 0; t < 5; t++) ipl_step(7'($urandom));

      // Region 0 read, no wait states.
      reg_din = {48'h0123_4567_89AB, 16'hBEEF};
      run_txn(23'h000010, 3'b101, 1'b1, 1);
      // Region 3 write: 5 wait states, then held for rdy[3] raised after 10 samples.
      reg_din = {$urandom, $urandom};
      run_txn(23'(3 << 15), 3'b101, 1'b0, 10);
      // Region 2 read with 2 wait states.
      run_txn(23'(2 << 15) | 23'h0055, 3'b110, 1'b1, 1);
      // Unmapped access times out.
      run_txn(23'h400000, 3'b101, 1'b1, 1);
      // Interrupt acknowledge autovectors.
      run_txn({20'hFFFFF, 3'd5}, 3'b111, 1'b1, 1);

      for (int t = 0; t < 14; t++) begin
         int pick;
         logic [23:1] a;
         logic [2:0] f;
         pick = $urandom_range(0, 5);
         reg_din = {$urandom, $urandom};
         f = 3'($urandom_range(1, 6));
         if (pick < 4)       a = 23'(pick << 15) | 23'($urandom_range(0, 16383));
         else if (pick == 4) a = 23'h400000 | 23'($urandom_range(0, 65535));
         else begin
            a = {20'hFFFFF, 3'($urandom_range(1, 7))};
            f = 3'b111;
         end
         run_txn(a, f, 1'($urandom), $urandom_range(1, 20));
      end

      for (int t = 0; t < 3; t++) run_abort($urandom_range(1, 8));

      // Reset pulsed mid-wait with the strobe still low: no ack until a fresh strobe.
      cpu_a = 23'(3 << 15); fc = 3'b101; rw = 1'b1; rdy = '0;
      uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      check_eq("midrst_state", 64'({dtack_n, berr_n, vpa_n, sel, we, re}), 64'(9'b111_0000_00));
      reset_n = 1'b1;
      rdy = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         tick();
         check_eq("midrst_noack", 64'({dtack_n, berr_n, vpa_n, sel}), 64'(7'b111_0000));
      end
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rdy = '0;
      tick();
      reg_din = {$urandom, $urandom};
      run_txn(23'h000020, 3'b101, 1'b1, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
